mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and select sequencer for the shared 4:1 gate-level multiplexer (data inputs i0..i3, selects s1/s0).
- Four requesters compete for the single mux output. The block grants one at a time and drives the mux select lines from registered state, so the selects are glitch-free.
- A grant is released on a done pulse, on withdrawal of the request, or on a hold timeout.
- Sits between the requesting agents and the mux instance.

Parameters:
- MAX_HOLD, 8, maximum cycles one grant may be held before forced release; 0 disables the timeout.
- CW, $clog2(MAX_HOLD+1), hold-counter width (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request from requester k on req[k], level-held.
- done  input  1  current owner finished; one-cycle pulse.
- grant  output  4  one-hot grant, registered; all zero when no owner.
- s1  output  1  mux select MSB (owner index bit 1).
- s0  output  1  mux select LSB (owner index bit 0).
- busy  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (rst_n low, async, effective immediately even mid-grant): state=IDLE, grant=4'b0000, s1=0, s0=0, busy=0, timeout=0, ptr=0, hold_cnt=0.
- States: IDLE, GRANT, GAP.
- Priority pointer ptr (2 bits): the search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- IDLE:
  - If req != 0 at edge N, select the first set bit in search order as owner.
  - After edge N: state=GRANT, grant=onehot(owner), {s1,s0}=owner, busy=1, hold_cnt=0.
  - Request-to-grant latency is 1 cycle.
  - If req == 0, stay in IDLE with outputs unchanged; {s1,s0} keeps the last owner index.
- GRANT, evaluated each edge in this priority order:
  - (a) done=1 -> release.
  - (b) req[owner]=0 -> release.
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 -> release with timeout=1 for the following cycle.
  - (d) otherwise hold_cnt++ and stay.
- Other requests never preempt the current owner.
- done has precedence over a coincident timeout: timeout stays 0.
- Release:
  - Next state is GAP: grant=0, busy=0, ptr=owner+1 mod 4.
  - s1/s0 hold the previous owner index, so the selects do not change while grant is low.
- GAP:
  - Lasts exactly one cycle, then goes to IDLE.
  - No arbitration occurs in GAP.
  - Minimum turnaround from release to the next grant is 2 cycles (GAP, then IDLE arbitration).
- done while in IDLE or GAP: ignored.
- req bits for non-owners may change freely in any state. The request is sampled only in IDLE.
- Invariants:
  - grant is always zero-or-one-hot.
  - When grant != 0, {s1,s0} equals the index of the set bit.
  - busy == |grant.
- hold_cnt saturates at MAX_HOLD-1 and is never read when MAX_HOLD=0; with MAX_HOLD=0 a grant can be held indefinitely.

Test Plan:
- Reset, then req=4'b0101 held: grant=0001, {s1,s0}=00 one cycle after the sampling edge. Pulse done: GAP cycle (grant=0000, sel still 00), IDLE cycle, then grant=0100, sel=10.
- req=4'b1111 held, done pulsed two cycles after each grant: grant order is 0001,0010,0100,1000,0001, with exactly 2 idle cycles (GAP+IDLE) between consecutive grants.
- MAX_HOLD=8, req=4'b0010 held, no done: grant=0010 for exactly 8 cycles, timeout pulses 1 cycle on GAP entry, then regrant to 0010 (only requester).
- Owner 2 granted, req[2] dropped while req[0]=1: release on the next edge, no timeout. Next grant is 0001, because ptr=3 wraps to 0.
- done and the timeout edge coincide (hold_cnt=7): release with timeout=0. rst_n pulled low mid-GRANT: grant=0000, sel=00, busy=0 immediately, without waiting for a clock edge.
- Randomized req/done for 10k cycles: checker asserts one-hot grant, sel==index(grant) while granted, busy==|grant, sel stable whenever grant==0, and no starvation (each held request granted within 3×(MAX_HOLD+2) cycles).

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter and select sequencer for a shared 4:1 mux
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // With MAX_HOLD=0 the derived width collapses to zero; keep one bit so the counter stays legal.
    localparam int HW = (CW > 0) ? CW : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

    state_t          state_q, state_d;
    logic [3:0]      grant_q, grant_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            timeout_q, timeout_d;

    logic [1:0]      pick;
    logic [1:0]      idx;
    logic            release_own;

    // First requester in the order ptr, ptr+1, ptr+2, ptr+3; walking backwards lets the earliest win.
    always_comb begin
        pick = ptr_q;
        idx  = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, hold/release in GRANT, single dead cycle in GAP.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        timeout_d   = 1'b0;
        release_own = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    grant_d = 4'b0001 << pick;
                    sel_d   = pick;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (done || !req[sel_q]) begin
                    release_own = 1'b1;
                end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST)) begin
                    release_own = 1'b1;
                    timeout_d   = 1'b1;
                end else if (MAX_HOLD != 0) begin
                    hold_d = hold_q + 1'b1;
                end
                // Selects keep the old owner index so the mux does not switch while grant is low.
                if (release_own) begin
                    state_d = GAP;
                    grant_d = 4'b0000;
                    ptr_d   = sel_q + 2'd1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset acts immediately, even mid-grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            sel_q     <= 2'd0;
            ptr_q     <= 2'd0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign s1      = sel_q[1];
    assign s0      = sel_q[0];
    assign busy    = (state_q == GRANT);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int LIMIT    = 3 * (MAX_HOLD + 2) + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] grant;
    logic       s1, s0, busy, timeout;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(grant), .s1(s1), .s0(s0), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the mux, for how long, and where the search starts next.
    bit m_owned, m_gap, m_to;
    int m_owner, m_ptr, m_held, m_sel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owned = 0; m_gap = 0; m_to = 0;
            m_owner = 0; m_ptr = 0; m_held = 0; m_sel = 0;
        end else begin
            m_to = 0;
            if (m_owned) begin
                if (done || !req[m_owner] || m_held + 1 == MAX_HOLD) begin
                    m_to    = !done && req[m_owner];
                    m_owned = 0;
                    m_gap   = 1;
                    m_ptr   = (m_owner + 1) % 4;
                end else begin
                    m_held++;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else if (req != 0) begin
                for (int i = 3; i >= 0; i--)
                    if (req[(m_ptr + i) % 4]) m_owner = (m_ptr + i) % 4;
                m_owned = 1;
                m_held  = 0;
                m_sel   = m_owner;
            end
        end
    end

    // Per-cycle comparison against the model, plus invariant and starvation tracking.
    int waitc [4] = '{0, 0, 0, 0};
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("grant", int'(grant), m_owned ? (1 << m_owner) : 0);
            chk("sel", int'({s1, s0}), m_sel);
            chk("busy", int'(busy), int'(m_owned));
            chk("timeout", int'(timeout), int'(m_to));
            chk("onehot", int'($countones(grant) <= 1), 1);
            chk("busy_eq_or", int'(busy), int'(|grant));
            for (int k = 0; k < 4; k++) begin
                if (grant[k] && waitc[k] > 0) begin
                    chk("starve_wait", int'(waitc[k] <= LIMIT), 1);
                    waitc[k] = 0;
                end else if (req[k] && !grant[k]) begin
                    waitc[k]++;
                end else begin
                    waitc[k] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_sel", int'({s1, s0}), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        // Basic grant and done release
        req = 4'b0101;
        tick(); chk("t1_grant0", int'(grant), 1); chk("t1_sel0", int'({s1, s0}), 0);
        done = 1'b1;
        tick(); done = 1'b0;
        chk("t1_gap", int'(grant), 0); chk("t1_gap_sel", int'({s1, s0}), 0);
        tick(); chk("t1_idle", int'(grant), 0);
        tick(); chk("t1_grant2", int'(grant), 4); chk("t1_sel2", int'({s1, s0}), 2);

        // Owner withdraws; pointer wraps from 3 to 0
        req = 4'b0001;
        tick(); chk("t4_rel", int'(grant), 0); chk("t4_noto", int'(timeout), 0);
        chk("t4_sel_hold", int'({s1, s0}), 2);
        tick();
        tick(); chk("t4_grant0", int'(grant), 1);

        // Hold timeout with a single requester
        req = 4'b0010;
        tick(); tick();
        tick(); chk("t3_grant1", int'(grant), 2);
        for (int i = 1; i < MAX_HOLD; i++) begin
            tick(); chk("t3_hold", int'(grant), 2);
        end
        tick(); chk("t3_rel", int'(grant), 0); chk("t3_to", int'(timeout), 1);
        tick(); chk("t3_to_clr", int'(timeout), 0);
        tick(); chk("t3_regrant", int'(grant), 2);

        // done coinciding with the timeout edge wins, no timeout pulse
        for (int i = 1; i < MAX_HOLD; i++) tick();
        done = 1'b1;
        tick(); done = 1'b0;
        chk("t5_rel", int'(grant), 0); chk("t5_noto", int'(timeout), 0);

        // Asynchronous reset mid-grant
        req = 4'b1111;
        tick();
        tick(); chk("t5_grant", int'(grant), 4);
        rst_n = 1'b0;
        #1;
        chk("t5_arst_grant", int'(grant), 0);
        chk("t5_arst_sel", int'({s1, s0}), 0);
        chk("t5_arst_busy", int'(busy), 0);
        tick(); rst_n = 1'b1;

        // Full rotation with two dead cycles between grants
        for (int k = 0; k < 5; k++) begin
            tick(); chk("t2_grant", int'(grant), 1 << (k % 4));
            tick(); done = 1'b1;
            tick(); done = 1'b0; chk("t2_gap", int'(grant), 0);
            tick(); chk("t2_idle", int'(grant), 0);
        end
        req = 4'b0000;
        tick(); tick(); tick();

        // Random traffic against the model
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(15) == 0) req[k] = ~req[k];
            done = ($urandom_range(9) == 0);
            tick();
        end
        done = 1'b0;
        for (int k = 0; k < 4; k++)
            chk("starve_end", int'(waitc[k] <= LIMIT), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
